// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding, oversample factor and
// the clock-divider helper used by the oversample tick generator.
package uart_pkg;

  localparam int OS_FACTOR = 16;
  localparam int MID_TICK  = OS_FACTOR / 2 - 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  function automatic int calc_div(input int clock_freq, input int baud);
    return clock_freq / (baud * OS_FACTOR);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Free-running oversample tick: a one-clk pulse every DIV clocks, where
// DIV = CLOCK_FREQ / (BAUD * OS_FACTOR) with integer truncation.
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 16000000,
  parameter int BAUD       = 9600
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = calc_div(CLOCK_FREQ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt_reg;
  logic          tick_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
      tick_reg    <= 1'b0;
    end else if (div_cnt_reg == LAST) begin
      div_cnt_reg <= '0;
      tick_reg    <= 1'b1;
    end else begin
      div_cnt_reg <= div_cnt_reg + CW'(1);
      tick_reg    <= 1'b0;
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/uart_rx_deser.sv
// UART receiver: 16x oversampled, LSB-first, 1 start / 1 stop bit, no parity,
// with a valid/ready output holding register plus frame-error and overrun pulses.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 16000000,
  parameter int BAUD       = 9600,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_in,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int OS_W  = $clog2(OS_FACTOR);
  localparam int BIT_W = $clog2(WIDTH + 1);

  logic             tick;
  logic             sync1_reg, sync2_reg;
  logic             rx_sync;
  rx_state_t        state_reg, state_next;
  logic [OS_W-1:0]  os_cnt_reg, os_cnt_next;
  logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [WIDTH:0]   shreg_ext;
  logic             byte_done, frame_bad;
  logic [WIDTH-1:0] rx_data_reg;
  logic             rx_valid_reg, frame_err_reg, overrun_reg;

  uart_os_tick #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD      (BAUD)
  ) u_os_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= rx_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign rx_sync   = sync2_reg;
  // New bit enters at the MSB so the first (LSB) bit ends up in bit 0.
  assign shreg_ext = {rx_sync, shreg_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      os_cnt_reg  <= '0;
      bit_cnt_reg <= '0;
      shreg_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      os_cnt_reg  <= os_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shreg_reg   <= shreg_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    os_cnt_next  = os_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    shreg_next   = shreg_reg;
    byte_done    = 1'b0;
    frame_bad    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_sync) begin
          state_next  = START;
          os_cnt_next = '0;
        end
      end
      START: begin
        if (tick) begin
          if (os_cnt_reg == OS_W'(MID_TICK)) begin
            os_cnt_next  = '0;
            bit_cnt_next = '0;
            state_next   = rx_sync ? IDLE : DATA;
          end else begin
            os_cnt_next = os_cnt_reg + OS_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (os_cnt_reg == OS_W'(OS_FACTOR - 1)) begin
            os_cnt_next  = '0;
            shreg_next   = shreg_ext[WIDTH:1];
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
            if (bit_cnt_reg == BIT_W'(WIDTH - 1)) begin
              state_next = STOP;
            end
          end else begin
            os_cnt_next = os_cnt_reg + OS_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (os_cnt_reg == OS_W'(OS_FACTOR - 1)) begin
            os_cnt_next  = '0;
            bit_cnt_next = '0;
            if (rx_sync) begin
              byte_done  = 1'b1;
              state_next = IDLE;
            end else begin
              frame_bad  = 1'b1;
              state_next = WAIT_HIGH;
            end
          end else begin
            os_cnt_next = os_cnt_reg + OS_W'(1);
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_sync) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A completing byte wins over a plain handshake clear, so simultaneous
  // accept-and-complete keeps rx_valid high with the new byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= frame_bad;
      overrun_reg   <= byte_done && rx_valid_reg && !rx_ready;
      if (byte_done && (!rx_valid_reg || rx_ready)) begin
        rx_data_reg  <= shreg_reg;
        rx_valid_reg <= 1'b1;
      end else if (rx_valid_reg && rx_ready) begin
        rx_valid_reg <= 1'b0;
      end
    end
  end

  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: table of single frames plus hand-written
// glitch, overrun, coincident-handshake and mid-frame reset sequences.
module tb_uart_rx_deser;

  localparam int CLOCK_FREQ = 16_000_000;
  localparam int BAUD       = 200_000;
  localparam int WIDTH      = 8;
  localparam int DIV        = CLOCK_FREQ / (BAUD * 16);
  localparam int BIT_CLK    = DIV * 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rx_in = 1'b1;
  logic             rx_ready = 1'b0;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             frame_err;
  logic             overrun;

  always #5 clk = ~clk;

  uart_rx_deser #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD      (BAUD),
    .WIDTH     (WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  int n_vec = 0;
  int n_err = 0;

  // Running totals of output activity, sampled mid-cycle.
  int         fe_tot = 0;
  int         ov_tot = 0;
  int         vld_tot = 0;
  int         both_tot = 0;
  logic [7:0] last_data = 8'h00;

  always @(negedge clk) begin
    if (frame_err) fe_tot = fe_tot + 1;
    if (overrun) ov_tot = ov_tot + 1;
    if (frame_err && overrun) both_tot = both_tot + 1;
    if (rx_valid) begin
      vld_tot   = vld_tot + 1;
      last_data = rx_data;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         exp_vld;
    logic [7:0] exp_data;
    int         exp_fe;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx_in = 1'b0;
    wait_clks(BIT_CLK);
    for (int i = 0; i < WIDTH; i++) begin
      rx_in = d[i];
      wait_clks(BIT_CLK);
    end
    rx_in = stop_bit;
    wait_clks(BIT_CLK);
    rx_in = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    int fe0, ov0, vld0;
    int found;

    vecs[0] = '{8'hB5, 1'b1, 1, 8'hB5, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
    vecs[3] = '{8'h3C, 1'b0, 0, 8'h00, 1};
    vecs[4] = '{8'h5A, 1'b1, 1, 8'h5A, 0};
    vecs[5] = '{8'hA5, 1'b1, 1, 8'hA5, 0};

    wait_clks(3);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    wait_clks(BIT_CLK);

    rx_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      fe0 = fe_tot; ov0 = ov_tot; vld0 = vld_tot;
      send_frame(vecs[v].data, vecs[v].stop_bit);
      wait_clks(2 * BIT_CLK);
      $display("vector %0d: data=0x%02h stop=%0b valid_cycles=%0d last_data=0x%02h frame_err=%0d",
               v, vecs[v].data, vecs[v].stop_bit, vld_tot - vld0, last_data, fe_tot - fe0);
      check("table_valid_cycles", vld_tot - vld0, vecs[v].exp_vld);
      if (vecs[v].exp_vld != 0) check("table_rx_data", int'(last_data), int'(vecs[v].exp_data));
      check("table_frame_err", fe_tot - fe0, vecs[v].exp_fe);
      check("table_overrun", ov_tot - ov0, 0);
    end

    // Short low glitch must be rejected, then a real frame still gets through.
    fe0 = fe_tot; vld0 = vld_tot;
    rx_in = 1'b0;
    wait_clks(3 * DIV);
    rx_in = 1'b1;
    wait_clks(2 * BIT_CLK);
    $display("glitch: valid_cycles=%0d frame_err=%0d", vld_tot - vld0, fe_tot - fe0);
    check("glitch_valid", vld_tot - vld0, 0);
    check("glitch_frame_err", fe_tot - fe0, 0);
    vld0 = vld_tot;
    send_frame(8'hC3, 1'b1);
    wait_clks(2 * BIT_CLK);
    $display("post_glitch: valid_cycles=%0d data=0x%02h", vld_tot - vld0, last_data);
    check("post_glitch_valid", vld_tot - vld0, 1);
    check("post_glitch_data", int'(last_data), 'hC3);

    // Overrun: two frames while the consumer stalls.
    rx_ready = 1'b0;
    fe0 = fe_tot; ov0 = ov_tot;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_clks(BIT_CLK);
    $display("overrun: data=0x%02h valid=%0b overrun_pulses=%0d", rx_data, rx_valid, ov_tot - ov0);
    check("overrun_rx_data", int'(rx_data), 'h11);
    check("overrun_rx_valid", int'(rx_valid), 1);
    check("overrun_pulses", ov_tot - ov0, 1);
    check("overrun_frame_err", fe_tot - fe0, 0);
    rx_ready = 1'b1;
    wait_clks(1);
    rx_ready = 1'b0;
    $display("overrun_drain: valid=%0b", rx_valid);
    check("overrun_drain_valid", int'(rx_valid), 0);

    // Handshake lands exactly in the completion cycle of the second frame.
    send_frame(8'h77, 1'b1);
    wait_clks(BIT_CLK);
    check("pending_valid", int'(rx_valid), 1);
    check("pending_data", int'(rx_data), 'h77);
    ov0 = ov_tot;
    rx_in = 1'b0;
    wait_clks(BIT_CLK);
    for (int i = 0; i < WIDTH; i++) begin
      rx_in = 8'h99 >> i;
      wait_clks(BIT_CLK);
    end
    rx_in = 1'b1;
    found = 0;
    for (int i = 0; i < 2 * BIT_CLK && found == 0; i++) begin
      @(negedge clk);
      if (dut.byte_done) found = 1;
    end
    check("completion_seen", found, 1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    $display("coincident: data=0x%02h valid=%0b", rx_data, rx_valid);
    check("coincident_data", int'(rx_data), 'h99);
    check("coincident_valid", int'(rx_valid), 1);
    wait_clks(BIT_CLK);
    check("coincident_overrun", ov_tot - ov0, 0);
    rx_ready = 1'b1;
    wait_clks(1);
    check("coincident_drain_valid", int'(rx_valid), 0);

    // Reset in the middle of bit 4 of 0xFF, with a byte still pending.
    rx_ready = 1'b0;
    send_frame(8'h42, 1'b1);
    wait_clks(BIT_CLK);
    check("prereset_valid", int'(rx_valid), 1);
    rx_in = 1'b0;
    wait_clks(BIT_CLK);
    rx_in = 1'b1;
    wait_clks(4 * BIT_CLK + BIT_CLK / 2);
    #2;
    rst_n = 1'b0;
    #1;
    $display("midframe_reset: data=0x%02h valid=%0b frame_err=%0b overrun=%0b",
             rx_data, rx_valid, frame_err, overrun);
    check("midreset_rx_valid", int'(rx_valid), 0);
    check("midreset_rx_data", int'(rx_data), 0);
    check("midreset_frame_err", int'(frame_err), 0);
    check("midreset_overrun", int'(overrun), 0);
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(BIT_CLK);
    rx_ready = 1'b1;
    fe0 = fe_tot; vld0 = vld_tot;
    send_frame(8'h81, 1'b1);
    wait_clks(2 * BIT_CLK);
    $display("post_reset: valid_cycles=%0d data=0x%02h", vld_tot - vld0, last_data);
    check("post_reset_valid", vld_tot - vld0, 1);
    check("post_reset_data", int'(last_data), 'h81);
    check("post_reset_frame_err", fe_tot - fe0, 0);

    check("err_overrun_exclusive", both_tot, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
